// File: rtl/ec_datapath.sv
// ---------------------------------------------------------------------------
// ec_datapath
//
// Accumulator-machine datapath that sits directly behind the control unit.
// It executes the CU strobes on the program counter, the instruction
// register, the accumulator A and a unified program/data RAM. In return it
// gives the CU its status inputs: the IR opcode, Aeq0 and Apos.
//
// Ports
//   CLOCK_50   in   1       system clock; all state changes on the rising edge
//   reset      in   1       asynchronous, active-low; clears PC, IR and A
//   Input      in   DATA_W  user data, loaded into A when Asel = 01
//   IRload     in   1       IR <= RAM read data
//   JMPmux     in   1       PC source: 1 = IR address field, 0 = PC + 1
//   PCload     in   1       load PC from the JMPmux-selected source
//   Meminst    in   1       RAM address: 1 = PC, 0 = IR address field
//   MemWr      in   1       write A into RAM at the selected address
//   Asel       in   2       A source: 00 add/sub, 01 Input, 10 RAM data, 11 zero
//   Aload      in   1       load A from the Asel source
//   Sub        in   1       add/sub select: 1 = A - rdata, 0 = A + rdata
//   prog_we    in   1       program-loader write strobe; overrides MemWr
//   prog_addr  in   ADDR_W  program-loader address
//   prog_data  in   DATA_W  program-loader data
//   IR         out  OPC_W   opcode field of the instruction register
//   Aeq0       out  1       A == 0
//   Apos       out  1       A > 0 when read as a signed value
//   PC         out  ADDR_W  program counter
//   Output     out  DATA_W  current accumulator value
//
// DATA_W must equal OPC_W + ADDR_W: an instruction word is one opcode field
// followed by one address field.
// ---------------------------------------------------------------------------
module ec_datapath #(
  parameter int    DATA_W   = 8,
  parameter int    ADDR_W   = 5,
  parameter int    OPC_W    = 3,
  parameter string MEM_INIT = ""
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] Input,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              Sub,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [OPC_W-1:0]  IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] Output
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;

  // A source encodings
  localparam logic [1:0] ASEL_ALU  = 2'b00;
  localparam logic [1:0] ASEL_IN   = 2'b01;
  localparam logic [1:0] ASEL_MEM  = 2'b10;
  localparam logic [1:0] ASEL_ZERO = 2'b11;

  // -------------------------------------------------------------------------
  // Architectural state
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] a_reg;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // -------------------------------------------------------------------------
  // RAM addressing and read
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] ir_field;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign ir_field  = ir_reg[ADDR_W-1:0];
  assign mem_addr  = Meminst ? pc_reg : ir_field;

  // Asynchronous read: the CU fetches and executes in the same cycle the
  // address is presented, so the word must be visible before the edge.
  // Everything that consumes rdata samples it at the edge, which is what
  // gives the "old contents" behaviour on a same-edge write.
  assign mem_rdata = mem[mem_addr];

  // -------------------------------------------------------------------------
  // Next-state selection
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] a_next;
  logic [ADDR_W-1:0] pc_next;

  // Carry and borrow fall off the top; there is no overflow flag.
  assign alu_result = Sub ? (a_reg - mem_rdata) : (a_reg + mem_rdata);

  always_comb begin
    a_next = a_reg;
    case (Asel)
      ASEL_ALU:  a_next = alu_result;
      ASEL_IN:   a_next = Input;
      ASEL_MEM:  a_next = mem_rdata;
      ASEL_ZERO: a_next = '0;
      default:   a_next = a_reg;
    endcase
  end

  // The jump target is the IR currently held, so a fetch that lands in IR on
  // the same edge does not affect where the PC goes. PC + 1 wraps naturally.
  assign pc_next = JMPmux ? ir_field : (pc_reg + ADDR_W'(1));

  // -------------------------------------------------------------------------
  // Register updates
  // -------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      pc_reg <= '0;
      ir_reg <= '0;
      a_reg  <= '0;
    end else begin
      if (PCload) pc_reg <= pc_next;
      if (IRload) ir_reg <= mem_rdata;
      if (Aload)  a_reg  <= a_next;
    end
  end

  // RAM write port. The loader owns the port whenever it strobes; a CU store
  // in the same cycle is dropped. A store always writes the pre-edge A, even
  // if A is reloaded on the same edge. RAM contents survive reset.
  always_ff @(posedge CLOCK_50) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end else if (MemWr) begin
      mem[mem_addr] <= a_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: pure functions of the registers, never of the control strobes
  // -------------------------------------------------------------------------
  assign IR     = ir_reg[DATA_W-1 -: OPC_W];
  assign PC     = pc_reg;
  assign Output = a_reg;
  assign Aeq0   = (a_reg == '0);
  assign Apos   = ~a_reg[DATA_W-1] & (a_reg != '0);

endmodule

// File: tb/tb_ec_datapath.sv
// ---------------------------------------------------------------------------
// tb_ec_datapath
//
// Scoreboard bench for ec_datapath. The driver issues one control word per
// clock, advances an architectural model of the machine (PC, IR, A and a
// 32-word memory written as plain integer arithmetic) and queues the visible
// state expected after that edge. An independent monitor pops one entry after
// each rising edge and compares it with the DUT outputs. The directed cases
// also check specific values directly. These cover reset, fetch, add/sub
// wrap, PC wrap, jump-with-fetch, store-with-clear and loader priority. A
// randomized run follows the directed cases.
// ---------------------------------------------------------------------------
module tb_ec_datapath;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] inp;
  logic       irload, jmpmux, pcload, meminst, memwr, aload, sub_s;
  logic [1:0] asel;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] ir_op;
  logic       aeq0, apos;
  logic [4:0] pc;
  logic [7:0] out_a;

  ec_datapath dut (
    .CLOCK_50 (clk),
    .reset    (rst_n),
    .Input    (inp),
    .IRload   (irload),
    .JMPmux   (jmpmux),
    .PCload   (pcload),
    .Meminst  (meminst),
    .MemWr    (memwr),
    .Asel     (asel),
    .Aload    (aload),
    .Sub      (sub_s),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .IR       (ir_op),
    .Aeq0     (aeq0),
    .Apos     (apos),
    .PC       (pc),
    .Output   (out_a)
  );

  typedef struct packed {
    logic [4:0] pc;
    logic [2:0] op;
    logic [7:0] a;
    logic       z;
    logic       p;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Architectural model
  int m_pc, m_ir, m_a;
  int m_mem[32];

  function automatic obs_t model_obs();
    obs_t e;
    e.pc = m_pc[4:0];
    e.op = m_ir[7:5];
    e.a  = m_a[7:0];
    e.z  = (m_a == 0);
    e.p  = (m_a >= 1 && m_a <= 127);
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t g;
    g.pc = pc;
    g.op = ir_op;
    g.a  = out_a;
    g.z  = aeq0;
    g.p  = apos;
    return g;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    compared++;
    if (got !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end else begin
      $display("check %s ok: %0h", name, got);
    end
  endtask

  task automatic clear_ctrl();
    irload = 0; jmpmux = 0; pcload = 0; meminst = 0; memwr = 0;
    asel = 2'b00; aload = 0; sub_s = 0; prog_we = 0;
  endtask

  // One machine cycle: drive on the falling edge, update the model, queue the
  // expected post-edge state, then release the strobes after the edge.
  task automatic cyc(input bit irl, input bit jmp, input bit pcl, input bit mi,
                     input bit mw, input bit [1:0] asl, input bit al, input bit sb,
                     input bit pw, input int pa, input int pd, input int ind);
    int addr, rd, src, n_pc, n_ir, n_a;
    @(negedge clk);
    irload = irl; jmpmux = jmp; pcload = pcl; meminst = mi; memwr = mw;
    asel = asl; aload = al; sub_s = sb; prog_we = pw;
    prog_addr = pa[4:0]; prog_data = pd[7:0]; inp = ind[7:0];

    addr = mi ? m_pc : (m_ir % 32);
    rd   = m_mem[addr];
    case (asl)
      2'd0:    src = sb ? (m_a - rd + 256) % 256 : (m_a + rd) % 256;
      2'd1:    src = ind % 256;
      2'd2:    src = rd;
      default: src = 0;
    endcase
    n_pc = pcl ? (jmp ? (m_ir % 32) : (m_pc + 1) % 32) : m_pc;
    n_ir = irl ? rd : m_ir;
    n_a  = al ? src : m_a;
    if (pw)      m_mem[pa % 32] = pd % 256;
    else if (mw) m_mem[addr]    = m_a;
    m_pc = n_pc; m_ir = n_ir; m_a = n_a;
    exp_q.push_back(model_obs());

    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  task automatic prog(input int a, input int d);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 1, a, d, 0);
  endtask

  task automatic load_a(input int v);
    cyc(0, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 0, v);
  endtask

  // Wait for the monitor to consume everything queued so far.
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one comparison per issued transaction, sampled after the edge.
  initial begin : monitor
    obs_t e, g;
    int   n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_obs();
        compared++;
        n++;
        if (g !== e) begin
          mismatched++;
          $display("FAIL txn %0d: got pc=%h op=%h a=%h z=%b p=%b required pc=%h op=%h a=%h z=%b p=%b",
                   n, g.pc, g.op, g.a, g.z, g.p, e.pc, e.op, e.a, e.z, e.p);
        end else begin
          $display("txn %0d ok: pc=%h op=%h a=%h z=%b p=%b", n, g.pc, g.op, g.a, g.z, g.p);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    obs_t rst_exp;
    rst_n = 1'b0;
    clear_ctrl();
    prog_addr = '0; prog_data = '0; inp = '0;
    m_pc = 0; m_ir = 0; m_a = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", 32'(dut_obs()), 32'(model_obs()));
    rst_n = 1'b1;

    // Fill the RAM so every later read is defined
    for (int i = 0; i < 32; i++) prog(i, int'($urandom_range(0, 255)));

    // Fetch: mem[0]=0x6A, IRload+PCload(+1) with Meminst=1
    prog(0, 8'h6A);
    cyc(1, 0, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    drain();
    check("fetch_opcode", 32'(ir_op), 32'd3);
    check("fetch_pc", 32'(pc), 32'd1);

    // Input load then subtract mem[0x0A]=7 -> 0xFE
    prog(8'h0A, 8'h07);
    load_a(5);
    drain();
    check("input_a", 32'(out_a), 32'h05);
    check("input_apos", 32'(apos), 32'd1);
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 0, 0);
    drain();
    check("sub_a", 32'(out_a), 32'hFE);
    check("sub_flags", 32'({aeq0, apos}), 32'd0);

    // 0xFF + 1 wraps to zero with the carry discarded
    load_a(8'hFF);
    prog(8'h0A, 8'h01);
    cyc(0, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0);
    drain();
    check("add_wrap_a", 32'(out_a), 32'h00);
    check("add_wrap_aeq0", 32'(aeq0), 32'd1);

    // PC = 31 via jump, then increment wraps to 0
    prog(1, 8'h1F);
    cyc(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    drain();
    check("jump_pc31", 32'(pc), 32'd31);
    cyc(0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    drain();
    check("pc_wrap", 32'(pc), 32'd0);

    // IR=0xB3; jump + fetch on the same edge uses the old IR field (0x13)
    prog(0, 8'hB3);
    cyc(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    prog(0, 8'h55);
    cyc(1, 1, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    drain();
    check("jump_old_ir_pc", 32'(pc), 32'h13);
    check("jump_new_ir_op", 32'(ir_op), 32'd2);

    // Store old A while clearing A (address = IR field 0x15)
    load_a(8'h42);
    cyc(0, 0, 0, 0, 1, 2'd3, 1, 0, 0, 0, 0, 0);
    drain();
    check("store_clr_a", 32'(out_a), 32'h00);
    cyc(0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    drain();
    check("store_readback", 32'(out_a), 32'h42);

    // Loader write wins over a simultaneous MemWr
    load_a(8'h11);
    cyc(0, 0, 0, 0, 1, 2'd0, 0, 0, 1, 3, 8'h99, 0);
    cyc(0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 0, 0);
    drain();
    check("prog_priority", 32'(out_a), 32'h42);

    // Asynchronous reset mid-cycle with A=0x5A and PC=7
    load_a(8'h5A);
    prog(8'h13, 8'h07);
    cyc(1, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0);
    drain();
    check("pre_reset_pc", 32'(pc), 32'd7);
    check("pre_reset_a", 32'(out_a), 32'h5A);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_pc = 0; m_ir = 0; m_a = 0;
    rst_exp = model_obs();
    check("async_reset", 32'(dut_obs()), 32'(rst_exp));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
